// File: rtl/encoder_pkg.sv
// Shared widths, reset constants and result type for the 4-to-2 priority encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package encoder_pkg;

    // Request vector width and encoded index width.
    localparam int ENC_IN_W  = 4;
    localparam int ENC_OUT_W = 2;

    // Values the registered outputs take while reset is asserted.
    // Reset reports "no request" so a consumer never acts on a stale index.
    localparam logic [ENC_OUT_W-1:0] ENC_RST_IDX     = 2'b00;
    localparam logic                 ENC_RST_INVALID = 1'b1;

    // Encoder result as carried between the core and the output register.
    typedef struct packed {
        logic [ENC_OUT_W-1:0] idx;
        logic                 none_set;
    } enc_res_t;

    // Result that stands for an all-zero request vector.
    localparam enc_res_t ENC_RES_NONE = '{idx: ENC_RST_IDX, none_set: 1'b1};

endpackage : encoder_pkg

// File: rtl/encoder_priority_core.sv
// Combinational 4-to-2 priority encode; direction selected by MSB_PRIORITY.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows d_in continuously.
module encoder_priority_core
    import encoder_pkg::*;
#(
    parameter int MSB_PRIORITY = 1
) (
    input  logic [ENC_IN_W-1:0]  d_in,
    output logic [ENC_OUT_W-1:0] idx,
    output logic                 none_set
);

    enc_res_t res;

    generate
        if (MSB_PRIORITY != 0) begin : g_msb_first
            // Highest-numbered set bit wins; all-zero falls through to "none".
            always_comb begin
                res = ENC_RES_NONE;
                casez (d_in)
                    4'b1???: res = '{idx: 2'd3, none_set: 1'b0};
                    4'b01??: res = '{idx: 2'd2, none_set: 1'b0};
                    4'b001?: res = '{idx: 2'd1, none_set: 1'b0};
                    4'b0001: res = '{idx: 2'd0, none_set: 1'b0};
                    default: res = ENC_RES_NONE;
                endcase
            end
        end else begin : g_lsb_first
            // Lowest-numbered set bit wins; all-zero falls through to "none".
            always_comb begin
                res = ENC_RES_NONE;
                casez (d_in)
                    4'b???1: res = '{idx: 2'd0, none_set: 1'b0};
                    4'b??10: res = '{idx: 2'd1, none_set: 1'b0};
                    4'b?100: res = '{idx: 2'd2, none_set: 1'b0};
                    4'b1000: res = '{idx: 2'd3, none_set: 1'b0};
                    default: res = ENC_RES_NONE;
                endcase
            end
        end
    endgenerate

    assign idx      = res.idx;
    assign none_set = res.none_set;

endmodule : encoder_priority_core

// File: rtl/encoder_priority_4_2.sv
// Registered 4-to-2 priority encoder with an all-zero (invalid) flag.
// Latency: 1 cycle from d_in sample to d_out/invalid_input; no comb path in->out.
// Backpressure: none; outputs update on every non-reset rising edge.
module encoder_priority_4_2
    import encoder_pkg::*;
#(
    parameter int MSB_PRIORITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ENC_IN_W-1:0]  d_in,
    output logic [ENC_OUT_W-1:0] d_out,
    output logic                 invalid_input
);

    logic [ENC_OUT_W-1:0] core_idx;
    logic                 core_none;

    logic [ENC_OUT_W-1:0] d_out_d,   d_out_q;
    logic                 invalid_d, invalid_q;

    encoder_priority_core #(
        .MSB_PRIORITY (MSB_PRIORITY)
    ) u_core (
        .d_in     (d_in),
        .idx      (core_idx),
        .none_set (core_none)
    );

    // Next state is the core result; the core already forces idx to 00 on all-zero input.
    always_comb begin
        d_out_d   = core_idx;
        invalid_d = core_none;
    end

    // Output register; reset wins over the encode result on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_out_q   <= ENC_RST_IDX;
            invalid_q <= ENC_RST_INVALID;
        end else begin
            d_out_q   <= d_out_d;
            invalid_q <= invalid_d;
        end
    end

    assign d_out         = d_out_q;
    assign invalid_input = invalid_q;

endmodule : encoder_priority_4_2

// File: tb/tb_encoder_priority_4_2.sv
// Scoreboard bench for both priority directions of the registered 4-to-2 encoder.
// Latency: expects results one rising edge after each sampled d_in.
// Backpressure: none; the monitor pops one expectation per edge per instance.
module tb_encoder_priority_4_2;
    import encoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d_in;
    logic [1:0] d_out_m, d_out_l;
    logic       inv_m, inv_l;

    always #5 clk = ~clk;

    encoder_priority_4_2 #(.MSB_PRIORITY(1)) dut_msb (
        .clk           (clk),
        .rst_n         (rst_n),
        .d_in          (d_in),
        .d_out         (d_out_m),
        .invalid_input (inv_m)
    );

    encoder_priority_4_2 #(.MSB_PRIORITY(0)) dut_lsb (
        .clk           (clk),
        .rst_n         (rst_n),
        .d_in          (d_in),
        .d_out         (d_out_l),
        .invalid_input (inv_l)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic       inv;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: scan bits in priority order, first set bit is the answer.
    function automatic exp_t ref_model(input logic [3:0] d, input bit in_reset, input bit msb);
        exp_t e;
        e.idx = 2'b00;
        e.inv = 1'b1;
        if (in_reset) return e;
        for (int k = 0; k < 4; k++) begin
            int b;
            b = msb ? (3 - k) : k;
            if (d[b]) begin
                e.idx = 2'(b);
                e.inv = 1'b0;
                return e;
            end
        end
        return e;
    endfunction

    task automatic compare(input string name, input logic [1:0] got_idx, input logic got_inv,
                           input exp_t e);
        checks++;
        if (got_idx !== e.idx || got_inv !== e.inv) begin
            errors++;
            $display("FAIL %s @%0t: got d_out=%b invalid=%b, expected d_out=%b invalid=%b",
                     name, $time, got_idx, got_inv, e.idx, e.inv);
        end
    endtask

    // Record what the next rising edge should produce for the current inputs.
    task automatic push_exp();
        q_m.push_back(ref_model(d_in, !rst_n, 1'b1));
        q_l.push_back(ref_model(d_in, !rst_n, 1'b0));
    endtask

    task automatic drive(input logic [3:0] d, input logic r);
        @(negedge clk);
        rst_n = r;
        d_in  = d;
        push_exp();
    endtask

    // Monitor: after every rising edge, pop one expectation per instance and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_m.size() > 0) compare("msb_out", d_out_m, inv_m, q_m.pop_front());
            if (q_l.size() > 0) compare("lsb_out", d_out_l, inv_l, q_l.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        d_in  = 4'b1010;

        // Reset held for two edges with a nonzero request, then released.
        drive(4'b1010, 1'b0);
        drive(4'b1010, 1'b0);
        drive(4'b1010, 1'b1);

        // Exhaustive sweep, both directions checked in parallel.
        for (int i = 0; i < 16; i++) drive(4'(i), 1'b1);
        for (int i = 15; i >= 0; i--) drive(4'(i), 1'b1);

        // Mid-cycle change: outputs must hold until the next edge.
        drive(4'b0100, 1'b1);
        @(posedge clk);
        #3;
        d_in = 4'b0001;
        push_exp();
        #1;
        compare("hold_msb", d_out_m, inv_m, ref_model(4'b0100, 1'b0, 1'b1));
        compare("hold_lsb", d_out_l, inv_l, ref_model(4'b0100, 1'b0, 1'b0));

        // Pulse entirely between edges: no effect on outputs.
        @(posedge clk);
        #2;
        d_in = 4'b1000;
        #2;
        d_in = 4'b0001;
        push_exp();
        #1;
        compare("pulse_msb", d_out_m, inv_m, ref_model(4'b0001, 1'b0, 1'b1));
        compare("pulse_lsb", d_out_l, inv_l, ref_model(4'b0001, 1'b0, 1'b0));

        // Reset asserted for one edge in the middle of a steady stream.
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b0);
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b1);

        // Invalid flag toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            drive(4'b0000, 1'b1);
            drive(4'b0010, 1'b1);
        end

        // Random requests with occasional reset edges.
        repeat (300) begin
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 15) != 0));
        end

        // Drain: every pushed expectation must have been consumed.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
                     q_m.size(), q_l.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_encoder_priority_4_2
